ctrl_reg_bank: RTL and testbench

Parametrised bank of host-writable control registers driven by the command decoder's per-source write strobes. It replaces the hand-written per-signal register block at the top level. Beyond plain latching, it adds per-register auto-clear pulse mode and a write-echo path. The echo path presents a confirmation message (index, value) to the command encoder through the standard have_msg/len/rd_req/out_data source interface.

---
 rtl/ctrl_reg_pkg.sv | 16 +
 rtl/ctrl_reg_bank_echo_fifo.sv | 56 +++++
 rtl/ctrl_reg_bank.sv | 141 ++++++++++++++
 tb/tb_ctrl_reg_bank.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_reg_pkg.sv
// ctrl_reg_pkg: shared constants and helpers for the control register bank.
package ctrl_reg_pkg;

    // Echo message layout: byte 0 carries the register index, byte 1 the value.
    localparam logic [7:0] ECHO_MSG_LEN  = 8'd2;
    localparam int         ECHO_BYTE_IDX = 0;
    localparam int         ECHO_BYTE_VAL = 1;

    // Width of a down-counter that must hold values 0 .. cycles-1.
    function automatic int pulse_cnt_w(input int cycles);
        int w;
        w = $clog2(cycles);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/ctrl_reg_bank_echo_fifo.sv
// echo_fifo: synchronous show-ahead FIFO of 16-bit echo words.
// The head word is always visible on dout; a push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module echo_fifo #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic [15:0] din,
    input  logic        pop,
    output logic [15:0] dout,
    output logic        full,
    output logic        empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [15:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // Storage array; contents need no reset because empty masks the head.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ctrl_reg_bank.sv
// ctrl_reg_bank: host-writable control registers with optional auto-clear
// pulse mode and a write-echo message source.
// Build option: define CTRL_REG_ECHO_EN to include the echo FIFO path;
// without it the echo outputs are tied to zero and rd_req is ignored.
//
// Source interface: have_msg is high while a message is pending and len
// gives its byte count. out_data shows the current byte; each cycle with
// rd_req=1 and have_msg=1 consumes that byte. rd_req while have_msg=0 is
// ignored.
module ctrl_reg_bank
    import ctrl_reg_pkg::*;
#(
    parameter int                      N_REGS       = 10,
    parameter int                      REG_W        = 8,
    parameter logic [N_REGS*REG_W-1:0] RST_VAL      = '0,
    parameter logic [N_REGS-1:0]       PULSE_MASK   = '0,
    parameter int                      PULSE_CYCLES = 48,
    parameter int                      ECHO_DEPTH   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [7:0]              m_din,
    input  logic [N_REGS-1:0]       m_wrreq,
    output logic [N_REGS*REG_W-1:0] regs,
    output logic [7:0]              out_data,
    output logic                    have_msg,
    output logic [7:0]              len,
    input  logic                    rd_req,
    output logic                    overflow
);

    localparam int              CW       = pulse_cnt_w(PULSE_CYCLES);
    localparam logic [CW-1:0]   CNT_LOAD = CW'(PULSE_CYCLES - 1);

    for (genvar i = 0; i < N_REGS; i++) begin : g_reg
        logic [REG_W-1:0] r_q;
        assign regs[REG_W*i +: REG_W] = r_q;

        if (PULSE_MASK[i]) begin : g_pulse
            logic [CW-1:0] cnt_q;
            logic          armed_q;
            // Pulse register: hold the written value PULSE_CYCLES cycles,
            // then fall back to the reset value.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_q     <= RST_VAL[REG_W*i +: REG_W];
                    cnt_q   <= '0;
                    armed_q <= 1'b0;
                end else if (m_wrreq[i]) begin
                    r_q     <= m_din[REG_W-1:0];
                    cnt_q   <= CNT_LOAD;
                    armed_q <= 1'b1;
                end else if (armed_q) begin
                    if (cnt_q == '0) begin
                        r_q     <= RST_VAL[REG_W*i +: REG_W];
                        armed_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
            end
        end else begin : g_plain
            // Plain register: latch on strobe, hold indefinitely.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_q <= RST_VAL[REG_W*i +: REG_W];
                end else if (m_wrreq[i]) begin
                    r_q <= m_din[REG_W-1:0];
                end
            end
        end
    end

`ifdef CTRL_REG_ECHO_EN
    logic [7:0]  echo_idx;
    logic [7:0]  echo_val;
    logic        echo_push;
    logic        fifo_pop;
    logic        fifo_full;
    logic        fifo_empty;
    logic [15:0] fifo_dout;
    logic        byte_ptr;
    logic        unused_ok;

    assign unused_ok = ^m_din;

    // Echo only the lowest strobed register; value is zero-extended.
    always_comb begin
        echo_idx = '0;
        echo_val = '0;
        echo_val[REG_W-1:0] = m_din[REG_W-1:0];
        for (int i = N_REGS - 1; i >= 0; i--) begin
            if (m_wrreq[i]) echo_idx = 8'(i);
        end
    end

    assign echo_push = |m_wrreq;
    assign fifo_pop  = rd_req && !fifo_empty && (byte_ptr == 1'(ECHO_BYTE_VAL));

    echo_fifo #(
        .DEPTH (ECHO_DEPTH)
    ) u_echo_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (echo_push),
        .din   ({echo_idx, echo_val}),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Byte pointer within the head message and sticky drop flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_ptr <= 1'(ECHO_BYTE_IDX);
            overflow <= 1'b0;
        end else begin
            if (rd_req && !fifo_empty) begin
                byte_ptr <= ~byte_ptr;
            end
            if (echo_push && fifo_full && !fifo_pop) begin
                overflow <= 1'b1;
            end
        end
    end

    assign have_msg = !fifo_empty;
    assign len      = have_msg ? ECHO_MSG_LEN : 8'd0;
    assign out_data = fifo_empty ? 8'd0 :
                      (byte_ptr == 1'(ECHO_BYTE_VAL)) ? fifo_dout[7:0] : fifo_dout[15:8];
`else
    logic unused_ok;
    assign unused_ok = ^{m_din, rd_req};
    assign have_msg  = 1'b0;
    assign len       = 8'd0;
    assign out_data  = 8'd0;
    assign overflow  = 1'b0;
`endif

endmodule

// File: tb/tb_ctrl_reg_bank.sv
// tb_ctrl_reg_bank: directed bench for ctrl_reg_bank (register, pulse and
// echo behaviour; echo checks follow the CTRL_REG_ECHO_EN build option).
module tb_ctrl_reg_bank;

    localparam int N_REGS = 10;
    localparam int REG_W  = 8;
    localparam logic [N_REGS*REG_W-1:0] RST_VAL = {{(6*8){1'b0}}, 8'hA5, {(3*8){1'b0}}};
    localparam logic [N_REGS-1:0] PULSE_MASK = 10'b00_0000_0010;
    localparam int PULSE_CYCLES = 48;
    localparam int ECHO_DEPTH   = 4;

    logic                    clk;
    logic                    rst;
    logic [7:0]              m_din;
    logic [N_REGS-1:0]       m_wrreq;
    logic [N_REGS*REG_W-1:0] regs;
    logic [7:0]              out_data;
    logic                    have_msg;
    logic [7:0]              len;
    logic                    rd_req;
    logic                    overflow;

    int tests_run;
    int tests_failed;

    ctrl_reg_bank #(
        .N_REGS       (N_REGS),
        .REG_W        (REG_W),
        .RST_VAL      (RST_VAL),
        .PULSE_MASK   (PULSE_MASK),
        .PULSE_CYCLES (PULSE_CYCLES),
        .ECHO_DEPTH   (ECHO_DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .m_din    (m_din),
        .m_wrreq  (m_wrreq),
        .regs     (regs),
        .out_data (out_data),
        .have_msg (have_msg),
        .len      (len),
        .rd_req   (rd_req),
        .overflow (overflow)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Checking
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] reg_at(input int i);
        return regs[REG_W*i +: REG_W];
    endfunction

    // Drivers (inputs change at negedge, outputs sampled at negedge)
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic write_reg(input int idx, input logic [7:0] val);
        m_din = val;
        m_wrreq = '0;
        m_wrreq[idx] = 1'b1;
        tick();
        m_wrreq = '0;
    endtask

    task automatic read_byte();
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
    endtask

    task automatic read_msg(input string tag, input logic [7:0] idx, input logic [7:0] val);
`ifdef CTRL_REG_ECHO_EN
        check({tag, "_have"}, 32'(have_msg), 32'd1);
        check({tag, "_len"},  32'(len), 32'd2);
        check({tag, "_b0"},   32'(out_data), 32'(idx));
        read_byte();
        check({tag, "_b1"},   32'(out_data), 32'(val));
        read_byte();
`else
        check({tag, "_have"}, 32'(have_msg), 32'd0);
        check({tag, "_data"}, 32'(out_data), 32'd0);
        read_byte();
`endif
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst     = 1'b1;
        m_din   = '0;
        m_wrreq = '0;
        rd_req  = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Reset state
        for (int i = 0; i < N_REGS; i++) begin
            check($sformatf("rst_reg%0d", i), 32'(reg_at(i)), (i == 3) ? 32'hA5 : 32'h0);
        end
        check("rst_have", 32'(have_msg), 32'd0);
        check("rst_len",  32'(len), 32'd0);
        check("rst_ovf",  32'(overflow), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);

        // Single write and echo
        write_reg(2, 8'h0C);
        check("wr_reg2", 32'(reg_at(2)), 32'h0C);
        read_msg("echo2", 8'h02, 8'h0C);
        check("echo2_done", 32'(have_msg), 32'd0);
        check("echo2_len0", 32'(len), 32'd0);

        // Pulse register 1: held exactly PULSE_CYCLES cycles
        write_reg(1, 8'h01);
        for (int c = 0; c < PULSE_CYCLES; c++) begin
            check($sformatf("pulse_hold%0d", c), 32'(reg_at(1)), 32'h01);
            tick();
        end
        check("pulse_clear", 32'(reg_at(1)), 32'h00);
        check("pulse_plain2", 32'(reg_at(2)), 32'h0C);

        // Rewrite at cycle 20 restarts the hold
        write_reg(1, 8'h01);
        repeat (19) tick();
        check("rewr_before", 32'(reg_at(1)), 32'h01);
        write_reg(1, 8'h02);
        for (int c = 0; c < PULSE_CYCLES; c++) begin
            check($sformatf("rewr_hold%0d", c), 32'(reg_at(1)), 32'h02);
            tick();
        end
        check("rewr_clear", 32'(reg_at(1)), 32'h00);
        read_msg("echo_p0", 8'h01, 8'h01);
        read_msg("echo_p1", 8'h01, 8'h01);
        read_msg("echo_p2", 8'h01, 8'h02);
        check("pulse_ovf", 32'(overflow), 32'd0);

        // Five writes into a four-deep FIFO
        for (int i = 0; i < 5; i++) write_reg(i, 8'(8'h10 + i));
        check("ovf_reg4", 32'(reg_at(4)), 32'h14);
`ifdef CTRL_REG_ECHO_EN
        check("ovf_set", 32'(overflow), 32'd1);
`else
        check("ovf_set", 32'(overflow), 32'd0);
`endif
        for (int i = 0; i < 4; i++) read_msg($sformatf("ovf_msg%0d", i), 8'(i), 8'(8'h10 + i));
        check("ovf_empty", 32'(have_msg), 32'd0);
`ifdef CTRL_REG_ECHO_EN
        check("ovf_sticky", 32'(overflow), 32'd1);
`else
        check("ovf_sticky", 32'(overflow), 32'd0);
`endif

        // Two strobes in one cycle: both update, lowest index echoed
        m_din   = 8'h33;
        m_wrreq = 10'b00_0010_0100;
        tick();
        m_wrreq = '0;
        check("multi_reg2", 32'(reg_at(2)), 32'h33);
        check("multi_reg5", 32'(reg_at(5)), 32'h33);
        read_msg("multi", 8'h02, 8'h33);
        check("multi_one", 32'(have_msg), 32'd0);

        // Reset in the middle of a message
        write_reg(7, 8'h55);
        read_byte();
`ifdef CTRL_REG_ECHO_EN
        check("mid_b1", 32'(out_data), 32'h55);
`endif
        rst = 1'b1;
        #1;
        check("mid_have", 32'(have_msg), 32'd0);
        check("mid_reg7", 32'(reg_at(7)), 32'h00);
        check("mid_ovf",  32'(overflow), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        write_reg(6, 8'h66);
        read_msg("post_rst", 8'h06, 8'h66);
        check("post_rst_empty", 32'(have_msg), 32'd0);

        // Full FIFO: final-byte pop and push on the same edge
        for (int i = 0; i < 4; i++) write_reg(i, 8'(8'h20 + i));
        read_byte();
        rd_req  = 1'b1;
        m_din   = 8'h88;
        m_wrreq = '0;
        m_wrreq[8] = 1'b1;
        tick();
        rd_req  = 1'b0;
        m_wrreq = '0;
        check("fullpp_reg8", 32'(reg_at(8)), 32'h88);
        check("fullpp_ovf",  32'(overflow), 32'd0);
        read_msg("fullpp1", 8'h01, 8'h21);
        read_msg("fullpp2", 8'h02, 8'h22);
        read_msg("fullpp3", 8'h03, 8'h23);
        read_msg("fullpp8", 8'h08, 8'h88);
        check("fullpp_empty", 32'(have_msg), 32'd0);
        check("fullpp_ovf2",  32'(overflow), 32'd0);

        // Final report
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
